fb_copy_writer: RTL and testbench
=================================

Name: fb_copy_writer

Overview:
- Receiving end of the shared-memory framebuffer copy stream (vga_copy / vga_addr_copy / vga_data / vga_end) that sh_mem emits after the task scheduler raises vga_en.
- Buffers copied pixels in a FIFO and writes them to the SRAM controller only during the sync window. Outside that window it serves vga_machine pixel reads.
- Replaces the direct "write only while blanking, else drop" glue, so no copied pixel is lost.

Parameters:
- ADDR_W, 12, shared-memory pixel address width
- DATA_W, 8, pixel width (REG_SIZE)
- SRAM_ADDR_W, 20, SRAM controller address width
- FB_BASE, 0, SRAM word offset of the framebuffer
- FIFO_DEPTH, 16, entry count; must be a power of 2 and at least 2

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- copy_valid  in  1  pixel present (from sh_mem vga_copy)
- copy_addr  in  ADDR_W  pixel address (vga_addr_copy)
- copy_data  in  DATA_W  pixel value (vga_data)
- copy_end  in  1  one-cycle pulse marking the end of the frame copy (vga_end)
- copy_ready  out  1  entry accepted this cycle when high with copy_valid
- blank  in  1  write window, = ~(h_sync & v_sync)
- pix_rd_addr  in  ADDR_W  vga_machine read address
- pix_rd_data  out  DATA_W  pixel returned to vga_machine
- sram_write  out  1  write strobe to SRAM controller
- sram_read  out  1  read strobe to SRAM controller
- sram_addr  out  SRAM_ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data (byte_en fixed at 2'b01 outside this block)
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after sram_read
- frame_done  out  1  one-cycle pulse once the last pixel of a frame is written
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (synchronous, active-high):
  - FIFO empty, pointers 0, FSM in IDLE.
  - All outputs 0 except sram_read=1 and copy_ready=1.
  - Reset mid-copy discards all buffered entries; no write is issued in the cycle after reset.
- FIFO:
  - Entries are {addr, data}. Read and write pointers carry one extra wrap bit.
  - full = (pointer MSBs differ) && (low bits equal); empty = (pointers equal).
  - Push = copy_valid && copy_ready. Pop = write issued this cycle.
  - Push and pop in the same cycle leave fifo_level unchanged.
- copy_ready = ~full && (state == IDLE || state == COPY). It is combinational from registered state.
  - A full FIFO does not accept a push even if a pop happens in the same cycle.
- FSM:
  - IDLE: copy_valid → COPY, accepting that entry. copy_end with no copy_valid → DONE (empty frame).
  - COPY: copy_end → FLUSH. If copy_valid and copy_end are high in the same cycle, the entry is accepted and is the last one.
  - FLUSH: copy_ready=0 and copy_valid is ignored. When the FIFO is empty with no write in flight → DONE.
  - DONE: frame_done=1 for exactly 1 cycle, then → IDLE.
- SRAM port (all outputs registered, one op per cycle):
  - blank=1 and FIFO non-empty: next cycle sram_write=1, sram_read=0, sram_addr=FB_BASE+zero-extended head addr, sram_wdata=head data; the entry is popped.
  - Otherwise: sram_read=1, sram_write=0, sram_addr=FB_BASE+pix_rd_addr.
  - sram_write and sram_read are never both 1.
- Read path:
  - pix_rd_data is registered from sram_rdata in the cycle after a read cycle, giving 2-cycle latency from pix_rd_addr.
  - During write cycles pix_rd_data holds its last value.
- Address arithmetic: FB_BASE+addr is truncated to SRAM_ADDR_W, so it wraps modulo 2^SRAM_ADDR_W.
- Ordering: writes are issued strictly in FIFO order. A later copy to the same address overwrites the earlier one.

Decomposition:
- Shared package/define file holds:
  - ADDR_W, DATA_W and SRAM_ADDR_W defaults, reusing the existing ADDR_SIZE/REG_SIZE defines.
  - FSM state encoding: IDLE=0, COPY=1, FLUSH=2, DONE=3.
- One sub-module, sync_fifo: parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty, level.
  - dout is first-word-fall-through.

Test Plan:
- Reset, then blank=1 with 3 pixels (addr 5/6/7, data 0x11/0x22/0x33) → writes to SRAM 5/6/7 with those data on consecutive cycles; frame_done pulses exactly once after copy_end.
- blank=0, 20 back-to-back copy_valid entries, FIFO_DEPTH=16 → copy_ready drops after 16 accepts and fifo_level=16. Raise blank → exactly 16 writes, then the remaining 4 are accepted; no entry is lost or reordered.
- blank=0, pix_rd_addr=0x040, SRAM model returns 0xA5 → pix_rd_data=0xA5 two cycles later. Toggling blank=1 with a non-empty FIFO → pix_rd_data holds 0xA5 during the writes.
- copy_valid and copy_end in the same cycle (addr 0xFFF, data 0x7E) with FB_BASE=0xFFFFF → the write goes to sram_addr=0x00FFE (wrap); frame_done follows that write.
- copy_end in IDLE with an empty FIFO → DONE, frame_done pulses 1 cycle, no sram_write.
- reset asserted with 5 entries buffered → next cycle fifo_level=0, sram_write=0, FSM IDLE, frame_done never pulses for that frame.

Source files
------------

// File: rtl/fb_copy_writer_pkg.sv
// Shared definitions for the framebuffer copy writer.
//   - Default widths, taken from the ADDR_SIZE / REG_SIZE defines used by
//     the rest of the system when they exist.
//   - FSM state encoding for the frame-copy controller.
`ifndef ADDR_SIZE
`define ADDR_SIZE 12
`endif
`ifndef REG_SIZE
`define REG_SIZE 8
`endif

package fb_copy_writer_pkg;

    localparam int ADDR_W_DEF      = `ADDR_SIZE;
    localparam int DATA_W_DEF      = `REG_SIZE;
    localparam int SRAM_ADDR_W_DEF = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COPY  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } fb_state_e;

endpackage : fb_copy_writer_pkg

// File: rtl/fb_copy_writer_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   push, din     write an entry (ignored when full)
//   pop           drop the head entry (ignored when empty)
//   dout          head entry, valid whenever empty is low
//   full, empty   occupancy flags
//   level         number of entries held, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign dout    = mem_q[rd_ptr_q[PW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (PW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (PW+1)'(do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= din;
        end
    end

endmodule : sync_fifo

// File: rtl/fb_copy_writer.sv
// Framebuffer copy writer: receives the sh_mem frame-copy stream, buffers the
// pixels, and writes them to the SRAM controller only while blank is high.
// All other cycles are read cycles serving vga_machine.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   copy_valid/addr/data/end, ready    copy stream from sh_mem
//   blank                              write window
//   pix_rd_addr, pix_rd_data           vga_machine read port (2-cycle latency)
//   sram_write/read/addr/wdata/rdata   SRAM controller port, one op per cycle
//   frame_done                         pulse after the last pixel is written
//   fifo_level                         current FIFO occupancy
module fb_copy_writer
    import fb_copy_writer_pkg::*;
#(
    parameter int                     ADDR_W      = ADDR_W_DEF,
    parameter int                     DATA_W      = DATA_W_DEF,
    parameter int                     SRAM_ADDR_W = SRAM_ADDR_W_DEF,
    parameter logic [SRAM_ADDR_W-1:0] FB_BASE     = '0,
    parameter int                     FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          copy_valid,
    input  logic [ADDR_W-1:0]             copy_addr,
    input  logic [DATA_W-1:0]             copy_data,
    input  logic                          copy_end,
    output logic                          copy_ready,
    input  logic                          blank,
    input  logic [ADDR_W-1:0]             pix_rd_addr,
    output logic [DATA_W-1:0]             pix_rd_data,
    output logic                          sram_write,
    output logic                          sram_read,
    output logic [SRAM_ADDR_W-1:0]        sram_addr,
    output logic [DATA_W-1:0]             sram_wdata,
    input  logic [DATA_W-1:0]             sram_rdata,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    fb_state_e state_q, state_d;

    logic                       fifo_full, fifo_empty;
    logic [ADDR_W+DATA_W-1:0]   fifo_dout;
    logic [ADDR_W-1:0]          head_addr;
    logic [DATA_W-1:0]          head_data;
    logic                       push, pop;

    logic                   sram_write_q, sram_write_d;
    logic                   sram_read_q,  sram_read_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q,  sram_addr_d;
    logic [DATA_W-1:0]      sram_wdata_q, sram_wdata_d;
    // Marks that sram_rdata carries the answer to last cycle's read.
    logic                   rd_pend_q,    rd_pend_d;
    logic [DATA_W-1:0]      pix_rd_data_q, pix_rd_data_d;

    assign copy_ready = !fifo_full && (state_q == ST_IDLE || state_q == ST_COPY);
    assign push       = copy_valid && copy_ready;
    assign pop        = blank && !fifo_empty;
    assign {head_addr, head_data} = fifo_dout;

    sync_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({copy_addr, copy_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A single-pixel frame can start and end in the same cycle.
                if (copy_valid)    state_d = copy_end ? ST_FLUSH : ST_COPY;
                else if (copy_end) state_d = ST_DONE;
            end
            ST_COPY: begin
                if (copy_end) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                // Wait until the last popped pixel has left the SRAM port.
                if (fifo_empty && !sram_write_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sram_write_d  = pop;
        sram_read_d   = !pop;
        sram_wdata_d  = pop ? head_data : sram_wdata_q;
        // Sum is taken at SRAM_ADDR_W bits, so it wraps past the top.
        sram_addr_d   = FB_BASE + (pop ? SRAM_ADDR_W'(head_addr) : SRAM_ADDR_W'(pix_rd_addr));
        rd_pend_d     = sram_read_q;
        pix_rd_data_d = rd_pend_q ? sram_rdata : pix_rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            sram_write_q  <= 1'b0;
            sram_read_q   <= 1'b1;
            sram_addr_q   <= '0;
            sram_wdata_q  <= '0;
            rd_pend_q     <= 1'b0;
            pix_rd_data_q <= '0;
        end else begin
            state_q       <= state_d;
            sram_write_q  <= sram_write_d;
            sram_read_q   <= sram_read_d;
            sram_addr_q   <= sram_addr_d;
            sram_wdata_q  <= sram_wdata_d;
            rd_pend_q     <= rd_pend_d;
            pix_rd_data_q <= pix_rd_data_d;
        end
    end

    assign sram_write  = sram_write_q;
    assign sram_read   = sram_read_q;
    assign sram_addr   = sram_addr_q;
    assign sram_wdata  = sram_wdata_q;
    assign pix_rd_data = pix_rd_data_q;
    assign frame_done  = (state_q == ST_DONE);

endmodule : fb_copy_writer

// File: tb/tb_fb_copy_writer.sv
// Directed bench for fb_copy_writer (FB_BASE = 0xFFFFF, so every SRAM
// address is pixel address - 1, modulo 2^20).
module tb_fb_copy_writer;

    localparam logic [19:0] BASE = 20'hFFFFF;

    logic        clk = 1'b0;
    logic        reset, copy_valid, copy_end, blank;
    logic [11:0] copy_addr, pix_rd_addr;
    logic [7:0]  copy_data, sram_rdata;
    logic        copy_ready, sram_write, sram_read, frame_done;
    logic [19:0] sram_addr;
    logic [7:0]  sram_wdata, pix_rd_data;
    logic [4:0]  fifo_level;

    int checks = 0, failures = 0;
    int cyc = 0, fd_count = 0, fd_cyc = 0, both_err = 0;
    logic [19:0] wl_addr [$];
    logic [7:0]  wl_data [$];
    int          wl_cyc  [$];

    fb_copy_writer #(
        .ADDR_W(12), .DATA_W(8), .SRAM_ADDR_W(20), .FB_BASE(BASE), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .reset(reset),
        .copy_valid(copy_valid), .copy_addr(copy_addr), .copy_data(copy_data),
        .copy_end(copy_end), .copy_ready(copy_ready), .blank(blank),
        .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
        .sram_write(sram_write), .sram_read(sram_read), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .frame_done(frame_done), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] exp_sram(input logic [11:0] a);
        return BASE + {8'h00, a};
    endfunction

    function automatic logic [7:0] rd_val(input logic [19:0] a);
        return (a == exp_sram(12'h040)) ? 8'hA5 : (a[7:0] ^ 8'h3C);
    endfunction

    // SRAM model: read data valid the cycle after sram_read; junk otherwise.
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        sram_rdata <= sram_read ? rd_val(sram_addr) : 8'h5C;
    end

    always @(negedge clk) begin
        if (sram_write) begin
            wl_addr.push_back(sram_addr);
            wl_data.push_back(sram_wdata);
            wl_cyc.push_back(cyc);
        end
        if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
        end
        if (sram_write && sram_read) both_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wl_addr.delete();
        wl_data.delete();
        wl_cyc.delete();
    endtask

    task automatic do_end();
        copy_valid = 1'b0;
        copy_end   = 1'b1;
        tick();
        copy_end   = 1'b0;
    endtask

    logic [7:0] t1_data [3] = '{8'h11, 8'h22, 8'h33};
    int fd0, idx;
    logic rdy;

    initial begin
        reset = 1'b1; copy_valid = 1'b0; copy_end = 1'b0; blank = 1'b0;
        copy_addr = '0; copy_data = '0; pix_rd_addr = 12'h041;
        tick(); tick();
        check("rst_sram_read",  32'(sram_read),   1);
        check("rst_copy_ready", 32'(copy_ready),  1);
        check("rst_sram_write", 32'(sram_write),  0);
        check("rst_frame_done", 32'(frame_done),  0);
        check("rst_level",      32'(fifo_level),  0);
        check("rst_addr",       32'(sram_addr),   0);
        check("rst_wdata",      32'(sram_wdata),  0);
        check("rst_pix",        32'(pix_rd_data), 0);
        reset = 1'b0;

        // Three pixels during blank.
        blank = 1'b1; clear_log(); fd0 = fd_count;
        for (int i = 0; i < 3; i++) begin
            copy_valid = 1'b1; copy_addr = 12'(5 + i); copy_data = t1_data[i];
            tick();
        end
        do_end();
        repeat (20) tick();
        check("t1_nwr", wl_addr.size(), 3);
        if (wl_addr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("t1_addr%0d", i), 32'(wl_addr[i]), 32'(exp_sram(12'(5 + i))));
                check($sformatf("t1_data%0d", i), 32'(wl_data[i]), 32'(t1_data[i]));
            end
            check("t1_consec", wl_cyc[2] - wl_cyc[0], 2);
            check("t1_done_after", 32'(fd_cyc > wl_cyc[2]), 1);
        end
        check("t1_fd", fd_count - fd0, 1);

        // 20 entries into a 16-deep FIFO while outside the write window.
        reset = 1'b1; tick(); reset = 1'b0;
        blank = 1'b0; clear_log(); fd0 = fd_count; idx = 0;
        for (int c = 0; c < 40 && idx < 16; c++) begin
            copy_valid = 1'b1; copy_addr = 12'(12'h100 + idx); copy_data = 8'(8'hC0 + idx);
            rdy = copy_ready; tick(); if (rdy) idx++;
        end
        for (int c = 0; c < 3; c++) begin
            copy_addr = 12'(12'h100 + idx); copy_data = 8'(8'hC0 + idx);
            rdy = copy_ready; tick(); if (rdy) idx++;
        end
        check("t2_accepts_full", idx, 16);
        check("t2_ready_low", 32'(copy_ready), 0);
        check("t2_level16", 32'(fifo_level), 16);
        check("t2_no_wr", wl_addr.size(), 0);
        blank = 1'b1;
        for (int c = 0; c < 60 && idx < 20; c++) begin
            copy_valid = 1'b1; copy_addr = 12'(12'h100 + idx); copy_data = 8'(8'hC0 + idx);
            rdy = copy_ready; tick(); if (rdy) idx++;
        end
        check("t2_accepts_all", idx, 20);
        do_end();
        repeat (30) tick();
        check("t2_nwr", wl_addr.size(), 20);
        if (wl_addr.size() == 20) begin
            for (int i = 0; i < 20; i++) begin
                check($sformatf("t2_addr%0d", i), 32'(wl_addr[i]), 32'(exp_sram(12'(12'h100 + i))));
                check($sformatf("t2_data%0d", i), 32'(wl_data[i]), 32'(8'(8'hC0 + i)));
            end
        end
        check("t2_fd", fd_count - fd0, 1);

        // Read path latency, then hold during writes.
        blank = 1'b0; pix_rd_addr = 12'h041;
        repeat (3) tick();
        pix_rd_addr = 12'h040;
        tick(); check("t3_lat0", 32'(pix_rd_data), 32'h7C);
        tick(); check("t3_lat1", 32'(pix_rd_data), 32'h7C);
        tick(); check("t3_lat2", 32'(pix_rd_data), 32'hA5);
        clear_log(); fd0 = fd_count;
        for (int i = 0; i < 3; i++) begin
            copy_valid = 1'b1; copy_addr = 12'(12'h200 + i); copy_data = 8'(1 + i);
            tick();
        end
        copy_valid = 1'b0;
        blank = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); check($sformatf("t3_hold%0d", i), 32'(pix_rd_data), 32'hA5);
        end
        do_end();
        repeat (20) tick();
        check("t3_nwr", wl_addr.size(), 3);
        check("t3_fd", fd_count - fd0, 1);

        // Single pixel with end in the same cycle; address wraps.
        clear_log(); fd0 = fd_count;
        copy_valid = 1'b1; copy_addr = 12'hFFF; copy_data = 8'h7E; copy_end = 1'b1;
        tick();
        copy_valid = 1'b0; copy_end = 1'b0;
        repeat (20) tick();
        check("t4_nwr", wl_addr.size(), 1);
        if (wl_addr.size() == 1) begin
            check("t4_addr", 32'(wl_addr[0]), 32'h00FFE);
            check("t4_data", 32'(wl_data[0]), 32'h7E);
            check("t4_done_after", 32'(fd_cyc > wl_cyc[0]), 1);
        end
        check("t4_fd", fd_count - fd0, 1);

        // Empty frame.
        clear_log(); fd0 = fd_count;
        do_end();
        repeat (10) tick();
        check("t5_nwr", wl_addr.size(), 0);
        check("t5_fd", fd_count - fd0, 1);

        // Reset with five entries buffered.
        blank = 1'b0; clear_log(); fd0 = fd_count;
        for (int i = 0; i < 5; i++) begin
            copy_valid = 1'b1; copy_addr = 12'(12'h300 + i); copy_data = 8'(8'h50 + i);
            tick();
        end
        copy_valid = 1'b0;
        check("t6_level5", 32'(fifo_level), 5);
        reset = 1'b1; blank = 1'b1;
        tick();
        check("t6_level0", 32'(fifo_level), 0);
        check("t6_no_write", 32'(sram_write), 0);
        check("t6_read", 32'(sram_read), 1);
        check("t6_ready", 32'(copy_ready), 1);
        check("t6_fd_low", 32'(frame_done), 0);
        reset = 1'b0;
        repeat (20) tick();
        check("t6_nwr", wl_addr.size(), 0);
        check("t6_fd", fd_count - fd0, 0);

        check("no_rw_overlap", both_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fb_copy_writer
